// File: rtl/task_dispatcher_if.sv
// Signal bundle between task_dispatcher and its environment:
// task intake, per-unit issue/completion, flush and drain handshake.
interface task_dispatcher_if #(
    parameter int NUM_UNITS = 4,
    parameter int DEPTH     = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 task_valid;
    logic                 task_ready;
    logic [1:0]           task_op;
    logic [1:0]           task_type;
    logic [3:0]           task_addr;
    logic [NUM_UNITS-1:0] unit_ready;
    logic [NUM_UNITS-1:0] unit_done;
    logic [NUM_UNITS-1:0] issue_vec;
    logic [1:0]           issue_op;
    logic [1:0]           issue_type;
    logic [3:0]           issue_addr;
    logic [NUM_UNITS-1:0] busy_units;
    logic [CW-1:0]        queue_count;
    logic [15:0]          done_count;
    logic                 flush;
    logic                 drain_req;
    logic                 drain_ack;
    logic                 idle;
    logic [1:0]           dbg_state;

    // Handshake: a task moves on every rising edge that sees task_valid && task_ready;
    // while task_valid is high and task_ready low the offering side holds op/type/addr.
    modport slave (
        input  task_valid, task_op, task_type, task_addr,
        input  unit_ready, unit_done, flush, drain_req,
        output task_ready, issue_vec, issue_op, issue_type, issue_addr,
        output busy_units, queue_count, done_count, drain_ack, idle, dbg_state
    );

    modport master (
        output task_valid, task_op, task_type, task_addr,
        output unit_ready, unit_done, flush, drain_req,
        input  task_ready, issue_vec, issue_op, issue_type, issue_addr,
        input  busy_units, queue_count, done_count, drain_ack, idle, dbg_state
    );
endinterface

// File: rtl/task_dispatcher.sv
// Queues incoming tasks and issues them one per cycle to free processing units
// in round-robin order, tracking outstanding work, completions and a drain handshake.
module task_dispatcher #(
    parameter int NUM_UNITS = 4,
    parameter int DEPTH     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    task_dispatcher_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [NUM_UNITS-1:0] ONE_HOT0 = NUM_UNITS'(1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t               r_state;
    logic [7:0]           r_mem [DEPTH];
    logic [AW-1:0]        r_rd_ptr;
    logic [AW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_count;
    logic [UW-1:0]        r_rr_ptr;
    logic [NUM_UNITS-1:0] r_busy;
    logic [NUM_UNITS-1:0] r_issue_vec;
    logic [1:0]           r_issue_op;
    logic [1:0]           r_issue_type;
    logic [3:0]           r_issue_addr;
    logic [15:0]          r_done_count;
    logic                 r_drain_ack;

    logic                 w_task_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_has_head;
    logic [7:0]           w_head;
    logic [NUM_UNITS-1:0] w_free;
    logic                 w_found;
    logic [UW-1:0]        w_grant_idx;
    logic                 w_issue;
    logic                 w_drop;
    logic [NUM_UNITS-1:0] w_grant_vec;
    logic [NUM_UNITS-1:0] w_done_hits;
    logic [3:0]           w_done_inc;
    logic [16:0]          w_done_sum;

    assign w_task_ready = rst_n && (r_state == S_RUN) && (r_count < CW'(DEPTH));
    assign w_push       = bus.task_valid && w_task_ready && !bus.flush;
    assign w_has_head   = (r_count != '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_free       = bus.unit_ready & ~r_busy;

    // First free unit at or after r_rr_ptr, wrapping past the last unit.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            int j;
            j = int'(r_rr_ptr) + k;
            if (j >= NUM_UNITS) j = j - NUM_UNITS;
            if (!w_found && w_free[j]) begin
                w_found     = 1'b1;
                w_grant_idx = UW'(j);
            end
        end
    end

    assign w_issue     = !bus.flush && w_has_head && (w_head[7:6] != 2'b00) && w_found;
    assign w_drop      = !bus.flush && w_has_head && (w_head[7:6] == 2'b00);
    assign w_pop       = w_issue || w_drop;
    assign w_grant_vec = w_issue ? (ONE_HOT0 << w_grant_idx) : '0;
    assign w_done_hits = bus.unit_done & r_busy;

    always_comb begin
        w_done_inc = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_done_inc = w_done_inc + 4'(w_done_hits[i]);
        end
    end

    assign w_done_sum = {1'b0, r_done_count} + 17'(w_done_inc);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {bus.task_op, bus.task_type, bus.task_addr};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_RUN;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_rr_ptr     <= '0;
            r_busy       <= '0;
            r_issue_vec  <= '0;
            r_issue_op   <= '0;
            r_issue_type <= '0;
            r_issue_addr <= '0;
            r_done_count <= '0;
            r_drain_ack  <= 1'b0;
        end else begin
            r_issue_vec <= w_grant_vec;
            if (w_issue) begin
                r_issue_op   <= w_head[7:6];
                r_issue_type <= w_head[5:4];
                r_issue_addr <= w_head[3:0];
                r_rr_ptr     <= (w_grant_idx == UW'(NUM_UNITS - 1)) ? '0 : w_grant_idx + UW'(1);
            end
            r_busy       <= (r_busy & ~bus.unit_done) | w_grant_vec;
            r_done_count <= w_done_sum[16] ? 16'hFFFF : w_done_sum[15:0];

            if (bus.flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end

            // Drain completes only once both the queue and every unit are empty.
            case (r_state)
                S_RUN: begin
                    if (bus.drain_req) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (r_count == '0 && r_busy == '0) begin
                        r_state     <= S_ACK;
                        r_drain_ack <= 1'b1;
                    end
                end
                S_ACK: begin
                    r_state     <= S_RUN;
                    r_drain_ack <= 1'b0;
                end
                default: begin
                    r_state     <= S_RUN;
                    r_drain_ack <= 1'b0;
                end
            endcase
        end
    end

    assign bus.task_ready  = w_task_ready;
    assign bus.issue_vec   = r_issue_vec;
    assign bus.issue_op    = r_issue_op;
    assign bus.issue_type  = r_issue_type;
    assign bus.issue_addr  = r_issue_addr;
    assign bus.busy_units  = r_busy;
    assign bus.queue_count = r_count;
    assign bus.done_count  = r_done_count;
    assign bus.drain_ack   = r_drain_ack;
    assign bus.idle        = (r_count == '0) && (r_busy == '0);
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_task_dispatcher.sv
// Directed scenarios followed by random traffic, each cycle compared against
// a queue-based behavioural model of the dispatcher.
module tb_task_dispatcher;
    localparam int NU    = 4;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    task_dispatcher_if #(.NUM_UNITS(NU), .DEPTH(DEPTH)) tif ();

    task_dispatcher #(.NUM_UNITS(NU), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: task list plus per-unit occupancy.
    logic [7:0]    exp_q[$];
    logic [NU-1:0] m_busy       = '0;
    int            m_rr         = 0;
    int            m_done       = 0;
    int            m_state      = 0;   // 0 running, 1 draining, 2 acknowledging
    logic [NU-1:0] m_issue_vec  = '0;
    logic [1:0]    m_issue_op   = '0;
    logic [1:0]    m_issue_type = '0;
    logic [3:0]    m_issue_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        logic [NU-1:0] grant;
        logic [7:0]    head;
        bit            ready;
        int            nxt;
        int            g;
        int            u;
        grant = '0;
        if (!rst_n) begin
            exp_q.delete();
            m_busy       = '0;
            m_rr         = 0;
            m_done       = 0;
            m_state      = 0;
            m_issue_vec  = '0;
            m_issue_op   = '0;
            m_issue_type = '0;
            m_issue_addr = '0;
            return;
        end
        ready = (m_state == 0) && (exp_q.size() < DEPTH);
        nxt = m_state;
        if (m_state == 0) begin
            if (tif.drain_req) nxt = 1;
        end else if (m_state == 1) begin
            if (exp_q.size() == 0 && m_busy == '0) nxt = 2;
        end else begin
            nxt = 0;
        end
        if (tif.flush) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) begin
                head = exp_q[0];
                if (head[7:6] == 2'b00) begin
                    void'(exp_q.pop_front());
                end else begin
                    g = -1;
                    for (int k = 0; k < NU; k++) begin
                        u = (m_rr + k) % NU;
                        if (g < 0 && tif.unit_ready[u] && !m_busy[u]) g = u;
                    end
                    if (g >= 0) begin
                        void'(exp_q.pop_front());
                        grant[g]     = 1'b1;
                        m_issue_op   = head[7:6];
                        m_issue_type = head[5:4];
                        m_issue_addr = head[3:0];
                        m_rr         = (g + 1) % NU;
                    end
                end
            end
            if (tif.task_valid && ready) exp_q.push_back({tif.task_op, tif.task_type, tif.task_addr});
        end
        m_done = m_done + $countones(tif.unit_done & m_busy);
        if (m_done > 65535) m_done = 65535;
        m_busy      = (m_busy & ~tif.unit_done) | grant;
        m_issue_vec = grant;
        m_state     = nxt;
    endtask

    task automatic compare_all();
        check("issue_vec",   tif.issue_vec,   m_issue_vec);
        check("issue_op",    tif.issue_op,    m_issue_op);
        check("issue_type",  tif.issue_type,  m_issue_type);
        check("issue_addr",  tif.issue_addr,  m_issue_addr);
        check("busy_units",  tif.busy_units,  m_busy);
        check("queue_count", tif.queue_count, exp_q.size());
        check("done_count",  tif.done_count,  m_done);
        check("drain_ack",   tif.drain_ack,   m_state == 2);
        check("task_ready",  tif.task_ready,  rst_n && m_state == 0 && exp_q.size() < DEPTH);
        check("idle",        tif.idle,        exp_q.size() == 0 && m_busy == '0);
    endtask

    // One clock: model advances with the inputs seen at the edge, outputs sampled 1 after.
    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        tif.task_valid = 1'b0;
        tif.task_op    = '0;
        tif.task_type  = '0;
        tif.task_addr  = '0;
        tif.unit_ready = '0;
        tif.unit_done  = '0;
        tif.flush      = 1'b0;
        tif.drain_req  = 1'b0;
    endtask

    task automatic offer(input logic [1:0] op, input logic [1:0] ty, input logic [3:0] ad);
        tif.task_valid = 1'b1;
        tif.task_op    = op;
        tif.task_type  = ty;
        tif.task_addr  = ad;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_ready_low", tif.task_ready, 0);
        check("rst_idle", tif.idle, 1);
        check("rst_qcount", tif.queue_count, 0);
        rst_n = 1'b1;
        step();

        // Four COMP tasks with every unit ready: one-hot issue walks 0..3.
        tif.unit_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            offer(2'b11, 2'(i), 4'(i));
            step();
            if (i > 0) check("rr_issue", tif.issue_vec, 32'(1) << (i - 1));
        end
        tif.task_valid = 1'b0;
        step();
        check("rr_issue_last", tif.issue_vec, 32'h8);
        check("rr_busy_all", tif.busy_units, 32'hF);
        tif.unit_done = 4'hF;
        step();
        tif.unit_done = '0;
        check("rr_done4", tif.done_count, 4);
        check("rr_busy_clear", tif.busy_units, 0);

        // Nine pushes with no unit ready: queue fills at eight.
        tif.unit_ready = '0;
        for (int i = 0; i < 8; i++) begin
            offer(2'b10, 2'(i), 4'(i + 3));
            step();
        end
        check("full_count", tif.queue_count, 8);
        check("full_ready_low", tif.task_ready, 0);
        step();
        check("full_ninth_held", tif.queue_count, 8);
        tif.task_valid = 1'b0;
        tif.flush      = 1'b1;
        step();
        tif.flush = 1'b0;
        check("full_flushed", tif.queue_count, 0);

        // Units 0 and 2 complete together; a done on idle unit 3 is ignored.
        tif.unit_ready = 4'b0101;
        offer(2'b11, 2'd1, 4'd9);
        step();
        offer(2'b11, 2'd2, 4'd10);
        step();
        tif.task_valid = 1'b0;
        step();
        check("done_busy02", tif.busy_units, 32'h5);
        tif.unit_ready = '0;
        tif.unit_done  = 4'b0101;
        step();
        check("done_plus2", tif.done_count, 6);
        check("done_busy_clear", tif.busy_units, 0);
        tif.unit_done = 4'b1000;
        step();
        tif.unit_done = '0;
        check("done_idle_ignored", tif.done_count, 6);

        // NOP at the head is dropped, then LOAD addr 5 is issued.
        tif.unit_ready = 4'hF;
        offer(2'b00, 2'd3, 4'd7);
        step();
        offer(2'b01, 2'd0, 4'd5);
        step();
        tif.task_valid = 1'b0;
        check("nop_no_issue", tif.issue_vec, 0);
        check("nop_count", tif.queue_count, 1);
        step();
        check("load_vec", tif.issue_vec, 32'h8);
        check("load_op", tif.issue_op, 1);
        check("load_addr", tif.issue_addr, 5);
        tif.unit_done = 4'b1000;
        step();
        tif.unit_done = '0;

        // Drain with three queued tasks.
        tif.unit_ready = '0;
        for (int i = 0; i < 3; i++) begin
            offer(2'b11, 2'(i), 4'(i + 12));
            step();
        end
        tif.task_valid = 1'b0;
        check("drain_q3", tif.queue_count, 3);
        tif.drain_req = 1'b1;
        step();
        tif.drain_req = 1'b0;
        check("drain_ready_low", tif.task_ready, 0);
        tif.unit_ready = 4'hF;
        repeat (3) step();
        check("drain_all_issued", tif.busy_units, 32'h7);
        tif.unit_ready = '0;
        tif.unit_done  = 4'b0111;
        step();
        tif.unit_done = '0;
        check("drain_ack_wait", tif.drain_ack, 0);
        step();
        check("drain_ack_pulse", tif.drain_ack, 1);
        check("drain_ack_ready", tif.task_ready, 0);
        step();
        check("drain_ack_end", tif.drain_ack, 0);
        check("drain_ready_back", tif.task_ready, 1);

        // Flush with five queued and a simultaneous push.
        for (int i = 0; i < 5; i++) begin
            offer(2'b01, 2'(i), 4'(i));
            step();
        end
        check("flush_q5", tif.queue_count, 5);
        offer(2'b10, 2'd1, 4'd1);
        tif.unit_ready = 4'hF;
        tif.flush      = 1'b1;
        step();
        tif.flush      = 1'b0;
        tif.task_valid = 1'b0;
        tif.unit_ready = '0;
        check("flush_empty", tif.queue_count, 0);
        check("flush_no_issue", tif.issue_vec, 0);

        // Reset mid-run discards everything; later completions are ignored.
        tif.unit_ready = 4'hF;
        for (int i = 0; i < 3; i++) begin
            offer(2'b11, 2'(i), 4'(i + 1));
            step();
        end
        rst_n = 1'b0;
        step();
        check("mrst_issue_vec", tif.issue_vec, 0);
        check("mrst_busy", tif.busy_units, 0);
        check("mrst_qcount", tif.queue_count, 0);
        check("mrst_done", tif.done_count, 0);
        check("mrst_ack", tif.drain_ack, 0);
        check("mrst_ready", tif.task_ready, 0);
        check("mrst_fields", {tif.issue_op, tif.issue_type, tif.issue_addr}, 0);
        rst_n = 1'b1;
        tif.task_valid = 1'b0;
        tif.unit_done  = 4'hF;
        step();
        tif.unit_done = '0;
        check("mrst_late_done", tif.done_count, 0);

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            tif.task_valid = ($urandom_range(0, 9) < 7);
            tif.task_op    = 2'($urandom_range(0, 3));
            tif.task_type  = 2'($urandom_range(0, 3));
            tif.task_addr  = 4'($urandom_range(0, 15));
            tif.unit_ready = NU'($urandom);
            tif.unit_done  = ($urandom_range(0, 2) == 0) ? NU'($urandom) : '0;
            tif.flush      = ($urandom_range(0, 39) == 0);
            tif.drain_req  = ($urandom_range(0, 29) == 0);
            rst_n          = ($urandom_range(0, 299) != 0);
            step();
        end

        rst_n = 1'b1;
        clear_inputs();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
